mem_port_ctrl: RTL and testbench
================================

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesting channels (0 = highest initial priority).
REQ-002 SHALL have parameter MAX_BYTES, default 4, largest transfer in bytes; allowed values 1, 2 or 4.
REQ-003 SHALL have parameter IO_STALL_EN, default 1, enables the IO-buffer-full write stall.
REQ-004 SHALL have ports clk_in  in  1  system clock; rst_in  in  1  reset; rdy_in  in  1  global enable, freeze when low.
REQ-005 SHALL use one clock, clk_in; reset rst_in is synchronous and active-low.
REQ-006 SHALL have ports mem_din  in  8  memory read byte; mem_dout  out  8  write byte; mem_a  out  32  byte address; mem_wr  out  1  1 = write.
REQ-007 SHALL have port io_buffer_full  in  1  UART buffer full.
REQ-008 SHALL have port clear_in  in  1  pipeline flush.
REQ-009 SHALL have per-port vectors req_valid  in  NUM_PORTS; req_wr  in  NUM_PORTS; req_len  in  3*NUM_PORTS; req_addr  in  32*NUM_PORTS; req_wdata  in  32*NUM_PORTS.
REQ-010 SHALL have outputs done  out  NUM_PORTS  one-hot completion pulse; rdata  out  32  read result, valid with done.
REQ-011 SHALL encode req_len as [1:0] 0=1 byte, 1=2 bytes, 2=4 bytes; [2]=1 sign-extend on read.

Function
REQ-012 SHALL use states IDLE, XFER, WAIT_IO, FINISH.
REQ-013 SHALL in IDLE grant one valid port by round-robin, starting after the last granted port.
REQ-014 SHALL drive byte 0 combinationally in the grant cycle (cycle 0), then byte k in cycle k, address req_addr+k.
REQ-015 SHALL latch len, addr, wdata, wr and port id at grant; requester holds req_valid and fields until done.
REQ-016 SHALL capture read byte k from mem_din in cycle k+1, little-endian into bits [8k+7:8k].
REQ-017 SHALL pulse done[p] for one cycle: cycle N for writes, cycle N+1 for reads (N = byte count); the done cycle is IDLE and may grant again.
REQ-018 SHALL zero-extend or sign-extend per len[2]; rdata is 0 when no done is high.
REQ-019 SHALL hold mem_wr=0, mem_dout=0 on every cycle not issuing a write byte.
REQ-020 SHALL, when IO_STALL_EN and granted write has addr[17:16]==2'b11 and io_buffer_full=1, enter WAIT_IO with mem_wr=0 and issue nothing until io_buffer_full=0.
REQ-021 SHALL, on clear_in=1, abort an in-flight or stalled read, produce no done, return to IDLE next cycle; in-flight writes complete normally.
REQ-022 SHALL ignore a read request whose port has req_valid dropped by clear_in in the same cycle as grant (no grant).
REQ-023 SHALL, with rdy_in=0, hold all state and force mem_wr=0.
REQ-024 SHALL treat req_len[1:0]=3 or a length > MAX_BYTES as 1 byte.
REQ-025 SHALL not wrap the address; req_addr+k uses full 32-bit addition.

Reset
REQ-026 SHALL, while rst_in=0 at a clock edge, set state IDLE, round-robin pointer to port 0, done=0, rdata=0, all latched fields 0.
REQ-027 SHALL drive mem_wr=0, mem_a=0, mem_dout=0 during and after reset until the first grant.
REQ-028 SHALL abort any transfer in progress when reset asserts mid-operation, with no done pulse.

Structure
REQ-029 SHALL place len encodings, IO address prefix 2'b11, and the state enumeration in shared package mem_ctrl_pkg.
REQ-030 SHALL instantiate one sub-module rr_arbiter (NUM_PORTS wide, grant one-hot, pointer advance on accept).

Verification
REQ-031 SHALL test a port-0 4-byte signed read at 0x100 with memory bytes 0x11,0x22,0x33,0x84 -> done[0] at cycle 5, rdata 0x84332211.
REQ-032 SHALL test a 1-byte signed read of 0xF0 -> 0xFFFFFFF0; the same unsigned -> 0x000000F0.
REQ-033 SHALL test both ports requesting continuously -> grants alternate 0,1,0,1; no port is starved.
REQ-034 SHALL test a write 0x41 to 0x30000 with io_buffer_full=1 for 7 cycles -> mem_wr stays 0, then one write cycle, done at release+1.
REQ-035 SHALL test clear_in at cycle 2 of a 4-byte read -> no done, IDLE next cycle; a concurrent 2-byte write completes with done.
REQ-036 SHALL test rst_in=0 mid-transfer -> all outputs 0 next cycle, pointer reset to port 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types, length encodings and helpers for mem_port_ctrl
//
// Purpose : controller state enumeration, req_len field encodings, IO window
//           address prefix, byte-count decode and read-data extension helpers.
// Ports   : none (package).
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_WAIT_IO = 2'd2,
        ST_FINISH  = 2'd3
    } state_t;

    // req_len[1:0] size codes; req_len[2] requests sign extension on reads.
    localparam logic [1:0] LEN_1B       = 2'd0;
    localparam logic [1:0] LEN_2B       = 2'd1;
    localparam logic [1:0] LEN_4B       = 2'd2;
    localparam int         LEN_SEXT_BIT = 2;

    // addr[17:16] of a write that targets the UART/IO buffer.
    localparam logic [1:0] IO_ADDR_PREFIX = 2'b11;

    // Reserved code 3 and any size larger than the port supports collapse to one byte.
    function automatic logic [2:0] len_bytes(input logic [1:0] code, input int max_bytes);
        logic [2:0] n;
        case (code)
            LEN_2B:  n = 3'd2;
            LEN_4B:  n = 3'd4;
            default: n = 3'd1;
        endcase
        if (int'(n) > max_bytes) begin
            n = 3'd1;
        end
        return n;
    endfunction

    function automatic logic [31:0] extend_rdata(input logic [31:0] raw,
                                                 input logic [2:0]  nbytes,
                                                 input logic        sext);
        logic [31:0] res;
        case (nbytes)
            3'd1:    res = {{24{sext & raw[7]}},  raw[7:0]};
            3'd2:    res = {{16{sext & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_port_ctrl_if.sv
// rtl/mem_port_ctrl_if.sv - requester-side bundle between channels and mem_port_ctrl
//
// Purpose : groups the per-port request vectors and the completion/result path.
// Signals : req_valid/req_wr [NUM_PORTS], req_len [3*NUM_PORTS],
//           req_addr/req_wdata [32*NUM_PORTS], done [NUM_PORTS] one-hot pulse,
//           rdata [32] valid with done.
// Modports: master = requesting channels, slave = controller.
interface mem_port_ctrl_if #(
    parameter int NUM_PORTS = 2
);
    logic [NUM_PORTS-1:0]    req_valid;
    logic [NUM_PORTS-1:0]    req_wr;
    logic [3*NUM_PORTS-1:0]  req_len;
    logic [32*NUM_PORTS-1:0] req_addr;
    logic [32*NUM_PORTS-1:0] req_wdata;
    logic [NUM_PORTS-1:0]    done;
    logic [31:0]             rdata;

    modport master (
        output req_valid, req_wr, req_len, req_addr, req_wdata,
        input  done, rdata
    );

    modport slave (
        input  req_valid, req_wr, req_len, req_addr, req_wdata,
        output done, rdata
    );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request arbiter with accept-driven pointer
//
// Purpose : picks one requester, searching from the port after the last accepted grant.
// Ports   : clk_in, rst_in (sync, active-low); i_req [NUM_PORTS] requests;
//           i_accept grant taken this cycle; o_grant one-hot; o_grant_idx index;
//           o_any some request is granted.
module rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_accept,
    output logic [NUM_PORTS-1:0] o_grant,
    output logic [PTR_W-1:0]     o_grant_idx,
    output logic                 o_any
);
    // r_ptr is the highest-priority port for the next arbitration.
    logic [PTR_W-1:0] r_ptr;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!o_any && i_req[(int'(r_ptr) + i) % NUM_PORTS]) begin
                o_any                                     = 1'b1;
                o_grant[(int'(r_ptr) + i) % NUM_PORTS]    = 1'b1;
                o_grant_idx = PTR_W'((int'(r_ptr) + i) % NUM_PORTS);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_ptr <= '0;
        end else if (i_accept && o_any) begin
            r_ptr <= PTR_W'((int'(o_grant_idx) + 1) % NUM_PORTS);
        end
    end
endmodule

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - multi-port byte-serial memory access controller
//
// Purpose : arbitrates NUM_PORTS requesters onto an 8-bit memory port, serialising
//           1/2/4-byte reads and writes little-endian, with an IO-buffer write stall
//           and pipeline-flush abort of reads.
// Ports   : clk_in, rst_in (sync, active-low), rdy_in (freeze when low),
//           clear_in (flush), io_buffer_full (UART buffer full),
//           mem_din [8] read byte (one cycle after its address),
//           mem_dout [8] / mem_a [32] / mem_wr memory command,
//           bus (mem_port_ctrl_if.slave) per-port requests, done and rdata.
module mem_port_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int MAX_BYTES   = 4,
    parameter int IO_STALL_EN = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_in,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    mem_port_ctrl_if.slave bus
);
    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    state_t               r_state;
    logic [PORT_W-1:0]    r_port;
    logic                 r_wr;
    logic                 r_sext;
    logic [2:0]           r_nbytes;
    logic [2:0]           r_idx;      // byte index issued in XFER
    logic [31:0]          r_addr;
    logic [31:0]          r_wdata;
    logic [31:0]          r_acc;      // read bytes gathered so far
    logic [NUM_PORTS-1:0] r_done;
    logic [31:0]          r_rdata;

    logic                 w_run;
    logic [NUM_PORTS-1:0] w_req_mask;
    logic [NUM_PORTS-1:0] w_grant;
    logic [PORT_W-1:0]    w_gnt_idx;
    logic                 w_any;
    logic                 w_take;
    logic                 w_g_wr;
    logic [2:0]           w_g_len;
    logic [2:0]           w_g_nbytes;
    logic [31:0]          w_g_addr;
    logic [31:0]          w_g_wdata;
    logic                 w_g_stall;
    logic                 w_abort_rd;
    logic [NUM_PORTS-1:0] w_port_oh;
    logic [2:0]           w_cap_idx;
    logic [5:0]           w_cap_sh;
    logic [31:0]          w_cap;
    logic                 w_issue;
    logic                 w_iss_wr;
    logic [31:0]          w_iss_addr;
    logic [7:0]           w_iss_byte;

    assign w_run = rst_in & rdy_in;

    // The port completing this cycle still holds req_valid, so keep it out of the
    // arbitration. Reads being flushed this cycle are not granted at all.
    assign w_req_mask = bus.req_valid & ~r_done & ~({NUM_PORTS{clear_in}} & ~bus.req_wr);

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PTR_W     (PORT_W)
    ) u_arb (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .i_req       (w_req_mask),
        .i_accept    (w_take),
        .o_grant     (w_grant),
        .o_grant_idx (w_gnt_idx),
        .o_any       (w_any)
    );

    assign w_take     = w_run && (r_state == ST_IDLE) && w_any;
    assign w_g_wr     = bus.req_wr[w_gnt_idx];
    assign w_g_len    = bus.req_len[3*w_gnt_idx +: 3];
    assign w_g_addr   = bus.req_addr[32*w_gnt_idx +: 32];
    assign w_g_wdata  = bus.req_wdata[32*w_gnt_idx +: 32];
    assign w_g_nbytes = len_bytes(w_g_len[1:0], MAX_BYTES);
    assign w_g_stall  = (IO_STALL_EN != 0) && w_g_wr &&
                        (w_g_addr[17:16] == IO_ADDR_PREFIX) && io_buffer_full;
    assign w_abort_rd = clear_in && !r_wr;

    always_comb begin
        w_port_oh = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_port_oh[p] = (r_port == PORT_W'(p));
        end
    end

    // Byte arriving on mem_din belongs to the address issued one cycle earlier.
    assign w_cap_idx = (r_state == ST_FINISH) ? (r_nbytes - 3'd1) : (r_idx - 3'd1);
    assign w_cap_sh  = {w_cap_idx, 3'b000};
    assign w_cap     = r_acc | ({24'b0, mem_din} << w_cap_sh);

    // Byte 0 goes out combinationally in the grant (or stall-release) cycle so a
    // transfer costs no idle cycle; later bytes come from the latched fields.
    always_comb begin
        w_issue    = 1'b0;
        w_iss_wr   = 1'b0;
        w_iss_addr = '0;
        w_iss_byte = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_take && !w_g_stall) begin
                    w_issue    = 1'b1;
                    w_iss_wr   = w_g_wr;
                    w_iss_addr = w_g_addr;
                    w_iss_byte = w_g_wdata[7:0];
                end
            end
            ST_WAIT_IO: begin
                if (w_run && !io_buffer_full) begin
                    w_issue    = 1'b1;
                    w_iss_wr   = r_wr;
                    w_iss_addr = r_addr;
                    w_iss_byte = r_wdata[7:0];
                end
            end
            ST_XFER: begin
                if (w_run && !w_abort_rd) begin
                    w_issue    = 1'b1;
                    w_iss_wr   = r_wr;
                    w_iss_addr = r_addr + {29'b0, r_idx};
                    w_iss_byte = r_wdata[{r_idx[1:0], 3'b000} +: 8];
                end
            end
            default: begin
            end
        endcase
    end

    assign mem_wr   = w_issue & w_iss_wr;
    assign mem_a    = w_issue ? w_iss_addr : 32'b0;
    assign mem_dout = mem_wr ? w_iss_byte : 8'b0;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state  <= ST_IDLE;
            r_port   <= '0;
            r_wr     <= 1'b0;
            r_sext   <= 1'b0;
            r_nbytes <= '0;
            r_idx    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_acc    <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
        end else if (rdy_in) begin
            r_done  <= '0;
            r_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_port   <= w_gnt_idx;
                        r_wr     <= w_g_wr;
                        r_sext   <= w_g_len[LEN_SEXT_BIT];
                        r_nbytes <= w_g_nbytes;
                        r_addr   <= w_g_addr;
                        r_wdata  <= w_g_wdata;
                        r_acc    <= '0;
                        if (w_g_stall) begin
                            r_state <= ST_WAIT_IO;
                            r_idx   <= 3'd0;
                        end else if (w_g_nbytes == 3'd1) begin
                            if (w_g_wr) begin
                                r_done <= w_grant;
                            end else begin
                                r_state <= ST_FINISH;
                            end
                        end else begin
                            r_state <= ST_XFER;
                            r_idx   <= 3'd1;
                        end
                    end
                end
                ST_WAIT_IO: begin
                    if (!io_buffer_full) begin
                        if (r_nbytes == 3'd1) begin
                            r_done  <= w_port_oh;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_XFER;
                            r_idx   <= 3'd1;
                        end
                    end
                end
                ST_XFER: begin
                    if (w_abort_rd) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (!r_wr) begin
                            r_acc <= w_cap;
                        end
                        if (r_idx == r_nbytes - 3'd1) begin
                            if (r_wr) begin
                                r_done  <= w_port_oh;
                                r_state <= ST_IDLE;
                            end else begin
                                r_state <= ST_FINISH;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                ST_FINISH: begin
                    // Only reads reach FINISH, so a flush here drops the result.
                    if (!clear_in) begin
                        r_done  <= w_port_oh;
                        r_rdata <= extend_rdata(w_cap, r_nbytes, r_sext);
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.done  = r_done;
    assign bus.rdata = r_rdata;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - directed self-checking bench for mem_port_ctrl
module tb_mem_port_ctrl;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_in;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int got;
    logic saw;

    mem_port_ctrl_if #(.NUM_PORTS(2)) bus ();

    mem_port_ctrl #(
        .NUM_PORTS   (2),
        .MAX_BYTES   (4),
        .IO_STALL_EN (1)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .io_buffer_full (io_buffer_full),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .bus            (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        logic [7:0] b;
        case (a)
            32'h100: b = 8'h11;
            32'h101: b = 8'h22;
            32'h102: b = 8'h33;
            32'h103: b = 8'h84;
            32'h200: b = 8'hF0;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Synchronous-read memory: data for the address of cycle k appears in cycle k+1.
    always @(posedge clk_in) begin
        mem_din <= rom_byte(mem_a);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic wr, input logic [2:0] len,
                           input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid[p]           = v;
        bus.req_wr[p]              = wr;
        bus.req_len[3*p +: 3]      = len;
        bus.req_addr[32*p +: 32]   = addr;
        bus.req_wdata[32*p +: 32]  = wd;
    endtask

    task automatic wait_done(input int max_cyc, output int c_out);
        c_out = -1;
        for (int c = 1; c <= max_cyc && c_out < 0; c++) begin
            step();
            if (bus.done != 2'b00) c_out = c;
        end
    endtask

    initial begin
        rst_in         = 1'b0;
        rdy_in         = 1'b1;
        clear_in       = 1'b0;
        io_buffer_full = 1'b0;
        bus.req_valid  = '0;
        bus.req_wr     = '0;
        bus.req_len    = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        // Reset, with a write pending that must not be issued.
        set_req(0, 1'b1, 1'b1, 3'b000, 32'h40, 32'h55);
        step();
        step();
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        bus.req_valid = '0;
        rst_in = 1'b1;
        step();

        // 4-byte signed read at 0x100.
        set_req(0, 1'b1, 1'b0, 3'b110, 32'h100, 32'h0);
        #1;
        chk("rd4_a_c0", mem_a, 32'h100);
        chk("rd4_wr_c0", 32'(mem_wr), 32'h0);
        step();
        step();
        step();
        chk("rd4_a_c3", mem_a, 32'h103);
        wait_done(10, cyc);
        chk("rd4_done_cycle", 32'((cyc < 0) ? -1 : cyc + 3), 32'd5);
        chk("rd4_done_vec", 32'(bus.done), 32'h1);
        chk("rd4_rdata", bus.rdata, 32'h84332211);
        bus.req_valid[0] = 1'b0;
        step();
        chk("rd4_done_clr", 32'(bus.done), 32'h0);
        chk("rd4_rdata_clr", bus.rdata, 32'h0);

        // 1-byte read of 0xF0, signed then unsigned.
        set_req(1, 1'b1, 1'b0, 3'b100, 32'h200, 32'h0);
        wait_done(6, cyc);
        chk("rd1s_cycle", 32'(cyc), 32'd2);
        chk("rd1s_done_vec", 32'(bus.done), 32'h2);
        chk("rd1s_rdata", bus.rdata, 32'hFFFFFFF0);
        bus.req_valid[1] = 1'b0;
        step();
        set_req(1, 1'b1, 1'b0, 3'b000, 32'h200, 32'h0);
        wait_done(6, cyc);
        chk("rd1u_cycle", 32'(cyc), 32'd2);
        chk("rd1u_rdata", bus.rdata, 32'h000000F0);
        bus.req_valid[1] = 1'b0;
        step();

        // Both ports requesting continuously: completions must alternate 0,1,0,1.
        set_req(0, 1'b1, 1'b1, 3'b000, 32'h40, 32'hA0);
        set_req(1, 1'b1, 1'b1, 3'b000, 32'h50, 32'hB1);
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            step();
            if (bus.done != 2'b00) begin
                chk($sformatf("rr_done%0d", got), 32'(bus.done), (got % 2 == 0) ? 32'h1 : 32'h2);
                got++;
            end
        end
        chk("rr_count", 32'(got), 32'd6);
        bus.req_valid = '0;
        step();
        step();

        // IO-window write stalled 7 cycles by io_buffer_full.
        io_buffer_full = 1'b1;
        set_req(0, 1'b1, 1'b1, 3'b000, 32'h30000, 32'h41);
        saw = 1'b0;
        for (int i = 0; i < 7; i++) begin
            #1;
            saw = saw | mem_wr;
            step();
        end
        chk("io_stall_wr", 32'(saw), 32'h0);
        io_buffer_full = 1'b0;
        #1;
        chk("io_rel_wr", 32'(mem_wr), 32'h1);
        chk("io_rel_a", mem_a, 32'h30000);
        chk("io_rel_dout", 32'(mem_dout), 32'h41);
        step();
        chk("io_done", 32'(bus.done), 32'h1);
        bus.req_valid[0] = 1'b0;
        step();

        // Flush at cycle 2 of a 4-byte read while a 2-byte write waits.
        set_req(0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        step();
        set_req(1, 1'b1, 1'b1, 3'b001, 32'h300, 32'h0000BEEF);
        step();
        clear_in = 1'b1;
        bus.req_valid[0] = 1'b0;
        step();
        clear_in = 1'b0;
        #1;
        chk("clr_c3_wr", 32'(mem_wr), 32'h1);
        chk("clr_c3_a", mem_a, 32'h300);
        chk("clr_c3_dout", 32'(mem_dout), 32'hEF);
        chk("clr_c3_done", 32'(bus.done), 32'h0);
        step();
        chk("clr_c4_a", mem_a, 32'h301);
        chk("clr_c4_dout", 32'(mem_dout), 32'hBE);
        step();
        chk("clr_c5_done", 32'(bus.done), 32'h2);
        chk("clr_c5_rdata", bus.rdata, 32'h0);
        bus.req_valid[1] = 1'b0;
        step();
        chk("clr_c6_done", 32'(bus.done), 32'h0);

        // Reset in the middle of a port-0 read; pointer must return to port 0.
        set_req(0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
        step();
        step();
        rst_in = 1'b0;
        bus.req_valid[0] = 1'b0;
        step();
        set_req(0, 1'b1, 1'b0, 3'b000, 32'h200, 32'h0);
        set_req(1, 1'b1, 1'b0, 3'b000, 32'h500, 32'h0);
        #1;
        chk("mid_rst_wr", 32'(mem_wr), 32'h0);
        chk("mid_rst_a", mem_a, 32'h0);
        chk("mid_rst_dout", 32'(mem_dout), 32'h0);
        chk("mid_rst_done", 32'(bus.done), 32'h0);
        chk("mid_rst_rdata", bus.rdata, 32'h0);
        step();
        rst_in = 1'b1;
        #1;
        chk("mid_rst_ptr_a", mem_a, 32'h200);
        wait_done(6, cyc);
        chk("mid_rst_p0_done", 32'(bus.done), 32'h1);
        chk("mid_rst_p0_rdata", bus.rdata, 32'h000000F0);
        bus.req_valid[0] = 1'b0;
        wait_done(6, cyc);
        chk("mid_rst_p1_done", 32'(bus.done), 32'h2);
        bus.req_valid[1] = 1'b0;
        step();

        // Reserved length code 3 behaves as a single byte.
        set_req(0, 1'b1, 1'b1, 3'b011, 32'h60, 32'h12345677);
        #1;
        chk("len3_dout", 32'(mem_dout), 32'h77);
        wait_done(6, cyc);
        chk("len3_cycle", 32'(cyc), 32'd1);
        bus.req_valid[0] = 1'b0;
        step();

        // rdy_in low freezes a 2-byte write and suppresses mem_wr.
        set_req(1, 1'b1, 1'b1, 3'b001, 32'h70, 32'h0000CDAB);
        #1;
        chk("rdy_c0_dout", 32'(mem_dout), 32'hAB);
        step();
        rdy_in = 1'b0;
        #1;
        chk("rdy_frz1_wr", 32'(mem_wr), 32'h0);
        step();
        chk("rdy_frz2_wr", 32'(mem_wr), 32'h0);
        rdy_in = 1'b1;
        #1;
        chk("rdy_res_a", mem_a, 32'h71);
        chk("rdy_res_dout", 32'(mem_dout), 32'hCD);
        step();
        chk("rdy_done", 32'(bus.done), 32'h2);
        bus.req_valid[1] = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
